// File: rtl/fight_pkg.sv
// Shared encodings for the fighting-game match sequencer: mode enum, winner codes,
// the START key, and the counter widths used by the strike gates.
package fight_pkg;

    typedef enum logic [2:0] {
        MODE_IDLE  = 3'd0,
        MODE_INTRO = 3'd1,
        MODE_FIGHT = 3'd2,
        MODE_KO    = 3'd3,
        MODE_OVER  = 3'd4
    } mode_t;

    localparam logic [1:0] WINNER_NONE = 2'd0;
    localparam logic [1:0] WINNER_P1   = 2'd1;
    localparam logic [1:0] WINNER_P2   = 2'd2;
    localparam logic [1:0] WINNER_DRAW = 2'd3;

    localparam logic [7:0] KEY_START = 8'h15;

    localparam int HIT_CNT_W  = 5;
    localparam int COOLDOWN_W = 6;

    // Hit counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [HIT_CNT_W-1:0] sat_inc(input logic [HIT_CNT_W-1:0] v);
        return (v == '1) ? v : v + HIT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/hit_gate.sv
// Strike gate for one defending player: invulnerability cooldown and the
// attacker's saturating per-round hit counter.
module hit_gate
    import fight_pkg::*;
#(
    parameter int HIT_COOLDOWN = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 strike_i,
    input  logic                 enable_i,
    input  logic                 clear_i,
    output logic                 hit_o,
    output logic [HIT_CNT_W-1:0] count_o
);

    logic [COOLDOWN_W-1:0] cooldown_q, cooldown_d;
    logic [HIT_CNT_W-1:0]  count_q, count_d;
    logic                  hit_q, hit_d;

    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        cooldown_d = cooldown_q;
        count_d    = count_q;
        hit_d      = 1'b0;
        if (clear_i) begin
            cooldown_d = '0;
            count_d    = '0;
        end else if (enable_i) begin
            if (strike_i && (cooldown_q == '0)) begin
                hit_d      = 1'b1;
                cooldown_d = COOLDOWN_W'(HIT_COOLDOWN);
                count_d    = sat_inc(count_q);
            end else if (cooldown_q != '0) begin
                cooldown_d = cooldown_q - COOLDOWN_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cooldown_q <= '0;
            count_q    <= '0;
            hit_q      <= 1'b0;
        end else begin
            cooldown_q <= cooldown_d;
            count_q    <= count_d;
            hit_q      <= hit_d;
        end
    end

    assign hit_o   = hit_q;
    assign count_o = count_q;

endmodule

// File: rtl/round_ctrl.sv
// Match sequencer: IDLE/INTRO/FIGHT/KO/MATCH_OVER FSM, round timer, win scoring,
// with one hit_gate per defending player arbitrating strikes into damage pulses.
module round_ctrl
    import fight_pkg::*;
#(
    parameter int ROUND_FRAMES  = 5400,
    parameter int INTRO_FRAMES  = 120,
    parameter int KO_FRAMES     = 180,
    parameter int HIT_COOLDOWN  = 20,
    parameter int ROUNDS_TO_WIN = 2
) (
    input  logic        frame_clk,
    input  logic        Reset_n,
    input  logic [7:0]  keycode,
    input  logic        p1_strike,
    input  logic        p2_strike,
    input  logic        p1_lose,
    input  logic        p2_lose,
    output logic        p1_hit,
    output logic        p2_hit,
    output logic        health_rst,
    output logic        fight_en,
    output logic [2:0]  game_mode,
    output logic [12:0] round_timer,
    output logic [1:0]  p1_wins,
    output logic [1:0]  p2_wins,
    output logic [1:0]  winner
);

    localparam int CNT_MAX = (INTRO_FRAMES > KO_FRAMES) ? INTRO_FRAMES : KO_FRAMES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] INTRO_LAST = CNT_W'(INTRO_FRAMES - 1);
    localparam logic [CNT_W-1:0] KO_LAST    = CNT_W'(KO_FRAMES - 1);
    localparam logic [1:0]       WIN_TARGET = 2'(ROUNDS_TO_WIN);

    mode_t                state_q, state_d;
    logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic [12:0]          timer_q, timer_d;
    logic [1:0]           p1_wins_q, p1_wins_d;
    logic [1:0]           p2_wins_q, p2_wins_d;
    logic [1:0]           winner_q, winner_d;
    logic                 health_rst_q, health_rst_d;
    logic                 fight_en_q;
    logic [7:0]           key_prev_q;

    logic                 start_edge;
    logic                 lose_end;
    logic                 time_end;
    logic [1:0]           round_winner;
    logic                 gate_en;
    logic                 gate_clear;
    logic [HIT_CNT_W-1:0] p1_landed;
    logic [HIT_CNT_W-1:0] p2_landed;

    // P2 defends against P1's strikes, so its gate counts the hits P1 lands.
    hit_gate #(.HIT_COOLDOWN(HIT_COOLDOWN)) u_gate_p2 (
        .clk      (frame_clk),
        .rst_n    (Reset_n),
        .strike_i (p1_strike),
        .enable_i (gate_en),
        .clear_i  (gate_clear),
        .hit_o    (p2_hit),
        .count_o  (p1_landed)
    );

    hit_gate #(.HIT_COOLDOWN(HIT_COOLDOWN)) u_gate_p1 (
        .clk      (frame_clk),
        .rst_n    (Reset_n),
        .strike_i (p2_strike),
        .enable_i (gate_en),
        .clear_i  (gate_clear),
        .hit_o    (p1_hit),
        .count_o  (p2_landed)
    );

    // A KO outranks the time-out; a time-out is decided on hits landed so far.
    always_comb begin
        start_edge = (keycode == KEY_START) && (key_prev_q != KEY_START);
        lose_end   = p1_lose || p2_lose;
        time_end   = (timer_q == 13'd1);
        if (lose_end) begin
            if (p1_lose && p2_lose) round_winner = WINNER_DRAW;
            else if (p1_lose)       round_winner = WINNER_P2;
            else                    round_winner = WINNER_P1;
        end else if (p1_landed > p2_landed) begin
            round_winner = WINNER_P1;
        end else if (p2_landed > p1_landed) begin
            round_winner = WINNER_P2;
        end else begin
            round_winner = WINNER_DRAW;
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        timer_d      = timer_q;
        p1_wins_d    = p1_wins_q;
        p2_wins_d    = p2_wins_q;
        winner_d     = winner_q;
        health_rst_d = 1'b0;
        gate_en      = 1'b0;
        gate_clear   = 1'b0;

        unique case (state_q)
            MODE_IDLE, MODE_OVER: begin
                if (start_edge) begin
                    p1_wins_d    = '0;
                    p2_wins_d    = '0;
                    winner_d     = WINNER_NONE;
                    health_rst_d = 1'b1;
                    frame_cnt_d  = '0;
                    state_d      = MODE_INTRO;
                end
            end
            MODE_INTRO: begin
                if (frame_cnt_q == INTRO_LAST) begin
                    timer_d    = 13'(ROUND_FRAMES);
                    gate_clear = 1'b1;
                    state_d    = MODE_FIGHT;
                end else begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end
            end
            MODE_FIGHT: begin
                timer_d = timer_q - 13'd1;
                if (lose_end || time_end) begin
                    winner_d    = round_winner;
                    frame_cnt_d = '0;
                    state_d     = MODE_KO;
                    if (round_winner == WINNER_P1 && p1_wins_q != WIN_TARGET)
                        p1_wins_d = p1_wins_q + 2'd1;
                    if (round_winner == WINNER_P2 && p2_wins_q != WIN_TARGET)
                        p2_wins_d = p2_wins_q + 2'd1;
                end else begin
                    gate_en = 1'b1;
                end
            end
            MODE_KO: begin
                if (frame_cnt_q == KO_LAST) begin
                    if (p1_wins_q == WIN_TARGET || p2_wins_q == WIN_TARGET) begin
                        state_d = MODE_OVER;
                    end else begin
                        health_rst_d = 1'b1;
                        winner_d     = WINNER_NONE;
                        frame_cnt_d  = '0;
                        state_d      = MODE_INTRO;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = MODE_IDLE;
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= MODE_IDLE;
            frame_cnt_q  <= '0;
            timer_q      <= 13'(ROUND_FRAMES);
            p1_wins_q    <= '0;
            p2_wins_q    <= '0;
            winner_q     <= WINNER_NONE;
            health_rst_q <= 1'b0;
            fight_en_q   <= 1'b0;
            key_prev_q   <= '0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            timer_q      <= timer_d;
            p1_wins_q    <= p1_wins_d;
            p2_wins_q    <= p2_wins_d;
            winner_q     <= winner_d;
            health_rst_q <= health_rst_d;
            fight_en_q   <= (state_d == MODE_FIGHT);
            key_prev_q   <= keycode;
        end
    end

    assign game_mode   = state_q;
    assign fight_en    = fight_en_q;
    assign health_rst  = health_rst_q;
    assign round_timer = timer_q;
    assign p1_wins     = p1_wins_q;
    assign p2_wins     = p2_wins_q;
    assign winner      = winner_q;

endmodule
